// File: rtl/booth_radix4_seq.sv
// ============================================================================
// Module      : booth_radix4_seq
// Description : Iterative radix-4 Booth multiplier, one Booth digit per clock,
//               signed/unsigned per transaction, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module booth_radix4_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int NDIG = WIDTH/2 + 1;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2*WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [EW:0]        mplier_q, mplier_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [EW-1:0]      w_a_ext;
  logic [EW-1:0]      w_b_ext;
  logic [AW-1:0]      w_mc2;
  logic [AW-1:0]      w_pp;
  logic [AW-1:0]      w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    w_a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    w_b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    w_mc2   = {mcand_q[AW-2:0], 1'b0};

    // The multiplicand is pre-shifted by 2i, so the digit only selects a multiple.
    case (mplier_q[2:0])
      3'b001, 3'b010: w_pp = mcand_q;
      3'b011:         w_pp = w_mc2;
      3'b100:         w_pp = -w_mc2;
      3'b101, 3'b110: w_pp = -mcand_q;
      default:        w_pp = '0;
    endcase
    w_sum = acc_q + w_pp;

    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{w_a_ext[EW-1]}}, w_a_ext};
          mplier_d = {w_b_ext, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = w_sum;
        mcand_d  = {mcand_q[AW-3:0], 2'b00};
        mplier_d = {{2{mplier_q[EW]}}, mplier_q[EW:2]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          product_d = w_sum[2*WIDTH-1:0];
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign product   = product_q;

endmodule

`default_nettype wire

// File: doc/booth_radix4_seq.md
Name: booth_radix4_seq

Overview:
- Parametrised, iterative radix-4 Booth multiplier. Successor to the 32x32 combinational Booth2 array.
- Retires one Booth digit (one partial product) per clock. Supports signed and unsigned operands, selected per transaction.
- Valid/ready handshakes on input and output let it sit between pipeline stages of the datapath in place of the large combinational multiplier.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- Derived (localparam, not overridable): NDIG = WIDTH/2 + 1, the Booth digits per operation. Counter width is $clog2(NDIG+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier (Booth-recoded operand).
- signed_mode  in  1  1 = both operands two's complement; 0 = both unsigned. Sampled at accept.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  full-precision result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, product=0, digit counter=0.
  - Internal operand and accumulator registers are cleared.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k, latch a and b extended to WIDTH+2 bits. Use sign extension if signed_mode=1, zero extension otherwise.
  - Append implicit bit b[-1]=0. Clear the accumulator, set the counter to 0, and go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, recode the digit {b[2i+1],b[2i],b[2i-1]} into {0,+A,+A,+2A,-2A,-A,-A,0}.
  - Add the partial product, shifted by 2i and formed at 2*WIDTH+2 bits, into the accumulator. Increment i.
  - After NDIG digits, i.e. at edge k+NDIG, load product with accumulator[2*WIDTH-1:0], set out_valid=1, and go to DONE.
  - Fixed latency: out_valid is first high NDIG cycles after the accept edge (17 for WIDTH=32). Latency is independent of data; there is no zero-digit skipping.
- DONE:
  - out_valid=1. product is held stable until the handshake.
  - On out_valid&&out_ready, clear out_valid and go to IDLE.
  - in_ready stays 0 in DONE, so no accept is possible in the same cycle as output completion. Peak throughput is one result per NDIG+2 cycles.
- Arithmetic:
  - Two-bit extension makes the result exact for all inputs in both modes.
  - Truncation to 2*WIDTH bits never loses information, including signed min*min and unsigned max*max.
  - The -2A term is formed as two's complement at full accumulator width. There is no separate sign-correction constant.
- Inputs a, b and signed_mode are ignored outside the accept cycle. Changing them mid-operation has no effect.
- Holding out_ready=1 continuously is legal. Asserting out_ready while out_valid=0 has no effect.
- Reset mid-operation aborts the operation immediately and returns the block to the reset state. No stale out_valid appears after reset deasserts.
- busy = (state != IDLE).

Test Plan:
- WIDTH=32, signed: a=0x80000000, b=0x80000000 -> product=0x4000000000000000, out_valid first high 17 cycles after the accept edge.
- WIDTH=32, unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. The same operands in signed mode -> product=0x0000000000000001.
- WIDTH=32, signed: a=0xFFFFFFFF (-1), b=2 -> product=0xFFFFFFFFFFFFFFFE. Unsigned 0*0x7FFFFFFF -> 0, with identical latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> product is stable, in_ready=0, and a new in_valid is not accepted. On out_ready=1, return to IDLE the next cycle.
- Reset mid-op: pull rst_n low 8 cycles into CALC -> all outputs at reset values immediately. After release, a fresh 3*5 signed operation gives product=15.
- WIDTH=8: exhaustive 256x256 in both modes against the $signed / unsigned reference product, with zero mismatches. Also run 10k random WIDTH=32 vectors.
